// File: rtl/pnl_serial_pkg.sv
// Shared definitions for the panel serial target.
//
// Contents:
//   DEF_WIDTH        default serial frame length in bits
//   DEF_SYNC_STAGES  default synchronizer depth for the host-driven inputs
//   state_t          frame state encoding used by pnl_serial_target
package pnl_serial_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no bits received yet in this frame
    ST_SHIFT = 2'd1,  // at least one bit received
    ST_LATCH = 2'd2   // frame closed by latch enable; lasts one cycle
  } state_t;

endpackage

// File: rtl/pnl_sync_edge.sv
// Multi-flop synchronizer with edge pulses for one asynchronous input.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   async_in  asynchronous input signal
//   level     synchronized level of async_in
//   rise      one-cycle pulse on a synchronized 0->1 transition
//   fall      one-cycle pulse on a synchronized 1->0 transition
module pnl_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   prev_lvl;
  // Shifts in ones after reset release; edges are only reported once the
  // synchronizer and the previous-level flop both hold real samples, so an
  // input that is already high at release never looks like a rising edge.
  logic [SYNC_STAGES:0]   fill;
  logic                   armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff  <= '0;
      prev_lvl <= 1'b0;
      fill     <= '0;
    end else begin
      sync_ff  <= {sync_ff[SYNC_STAGES-2:0], async_in};
      prev_lvl <= sync_ff[SYNC_STAGES-1];
      fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign armed = fill[SYNC_STAGES];
  assign level = sync_ff[SYNC_STAGES-1];
  assign rise  = armed &  level & ~prev_lvl;
  assign fall  = armed & ~level &  prev_lvl;

endmodule

// File: rtl/pnl_serial_target.sv
// Serial target for a host-clocked shift link (SPI-like, MSB first).
// Everything runs on csi_MCLK_clk; the host ser_clk/ser_le/ser_sdi lines
// are oversampled through synchronizers and handled as edge events.
//
// Ports:
//   csi_MCLK_clk      system clock
//   rsi_MRST_reset_n  asynchronous active-low reset
//   ser_sdi           serial data from host
//   ser_clk           host shift clock (sampled, not used as a clock)
//   ser_le            host latch enable; rising edge closes the frame
//   ser_sdo           serial data to host (MSB of the tx shift register)
//   ser_sta           1 when the last frame held exactly WIDTH bits
//   din               word returned to the host during the next frame
//   dout              last correctly sized received word
//   dout_valid        one-cycle pulse when dout is updated
//   frame_err         one-cycle pulse when a frame had the wrong length
module pnl_serial_target
  import pnl_serial_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset_n,
  input  logic             ser_sdi,
  input  logic             ser_clk,
  input  logic             ser_le,
  output logic             ser_sdo,
  output logic             ser_sta,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err
);

  // Counter must reach WIDTH+1 so an over-long frame stays distinguishable.
  localparam int              CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  logic sdi_lvl;
  logic clk_rise;
  logic clk_fall;
  logic le_rise;
  logic sdi_edge_unused;
  logic sdi_rise;
  logic sdi_fall;
  logic clk_lvl_unused;
  logic le_lvl;
  logic le_fall;

  pnl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk      (csi_MCLK_clk),
    .rst_n    (rsi_MRST_reset_n),
    .async_in (ser_sdi),
    .level    (sdi_lvl),
    .rise     (sdi_rise),
    .fall     (sdi_fall)
  );

  pnl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk      (csi_MCLK_clk),
    .rst_n    (rsi_MRST_reset_n),
    .async_in (ser_clk),
    .level    (clk_lvl_unused),
    .rise     (clk_rise),
    .fall     (clk_fall)
  );

  pnl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_le (
    .clk      (csi_MCLK_clk),
    .rst_n    (rsi_MRST_reset_n),
    .async_in (ser_le),
    .level    (le_lvl),
    .rise     (le_rise),
    .fall     (le_fall)
  );

  // Only the level of ser_sdi matters, and only the rising edge of ser_le.
  assign sdi_edge_unused = sdi_rise | sdi_fall | le_lvl | le_fall;

  state_t           state;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] tx_sr;
  logic [CNT_W-1:0] bit_cnt;

  assign ser_sdo = tx_sr[WIDTH-1];

  // The frame verdict, tx reload and rx/count clear are all taken on the
  // edge that enters LATCH. That puts dout/dout_valid/frame_err on the
  // cycle right after the ser_le rise is seen, while LATCH is the current
  // state, and the count checked is the one from before any ser_clk edge
  // that coincided with the ser_le rise (that edge is dropped).
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state      <= ST_IDLE;
      rx_sr      <= '0;
      tx_sr      <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      ser_sta    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (le_rise) begin
        state <= ST_LATCH;
        if (bit_cnt == CNT_FULL) begin
          dout       <= rx_sr;
          dout_valid <= 1'b1;
          ser_sta    <= 1'b1;
        end else begin
          frame_err  <= 1'b1;
          ser_sta    <= 1'b0;
        end
        tx_sr   <= din;
        rx_sr   <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_SHIFT: begin
            if (clk_rise) state <= ST_SHIFT;
          end
          ST_LATCH: begin
            // A bit may already arrive in the LATCH cycle (ser_le still high).
            state <= clk_rise ? ST_SHIFT : ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase

        if (clk_rise) begin
          rx_sr <= {rx_sr[WIDTH-2:0], sdi_lvl};
          if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
        end

        // Host samples ser_sdo on its rising edge; advance on the falling one.
        if (clk_fall) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_pnl_serial_target.sv
// Directed self-checking bench for pnl_serial_target (WIDTH 32, SYNC_STAGES 2).
module tb_pnl_serial_target;

  logic        clk;
  logic        rst_n;
  logic        ser_sdi;
  logic        ser_clk;
  logic        ser_le;
  logic        ser_sdo;
  logic        ser_sta;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_valid;
  logic        frame_err;

  int nchecks = 0;
  int nerrors = 0;
  int nvalid  = 0;
  int nerr    = 0;

  pnl_serial_target #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .csi_MCLK_clk     (clk),
    .rsi_MRST_reset_n (rst_n),
    .ser_sdi          (ser_sdi),
    .ser_clk          (ser_clk),
    .ser_le           (ser_le),
    .ser_sdo          (ser_sdo),
    .ser_sta          (ser_sta),
    .din              (din),
    .dout             (dout),
    .dout_valid       (dout_valid),
    .frame_err        (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid) nvalid++;
    if (frame_err)  nerr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One host bit: data set, ser_clk high 8 MCLK, low 8 MCLK. sdo sampled at rise.
  task automatic ser_bit(input logic b, output logic so);
    @(negedge clk) ser_sdi = b;
    repeat (4) @(negedge clk);
    so = ser_sdo;
    ser_clk = 1'b1;
    repeat (8) @(negedge clk);
    ser_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] val, input int n, output logic [31:0] cap);
    logic so;
    cap = '0;
    for (int i = n - 1; i >= 0; i--) begin
      ser_bit(val[i], so);
      cap = {cap[30:0], so};
    end
  endtask

  // Called right after ser_le is raised at a falling MCLK edge: two cycles of
  // synchronizer, one cycle to register, then exactly one pulse cycle.
  task automatic pulse_check(input string tag, input logic exp_valid);
    repeat (2) @(negedge clk);
    check({tag, "_pre"}, {30'd0, dout_valid, frame_err}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, dout_valid}, {31'd0, exp_valid});
    check({tag, "_err"}, {31'd0, frame_err}, {31'd0, ~exp_valid});
    @(negedge clk);
    check({tag, "_post"}, {30'd0, dout_valid, frame_err}, 32'd0);
  endtask

  task automatic latch(input string tag, input logic exp_valid);
    @(negedge clk) ser_le = 1'b1;
    pulse_check(tag, exp_valid);
    repeat (6) @(negedge clk);
    ser_le = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  logic [31:0] cap;
  int          v0, e0;

  initial begin
    rst_n = 1'b0; ser_sdi = 1'b0; ser_clk = 1'b0; ser_le = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_dout", dout, 32'h0);
    check("rst_sdo",  {31'd0, ser_sdo}, 32'd0);
    check("rst_sta",  {31'd0, ser_sta}, 32'd0);
    check("rst_pulses", {30'd0, dout_valid, frame_err}, 32'd0);

    // Good frame; tx was cleared by reset so host reads zeros
    din = 32'h8000_0001;
    send_bits(64'hA5C3_0F96, 32, cap);
    check("f1_sdo_word", cap, 32'h0);
    latch("f1", 1'b1);
    check("f1_dout", dout, 32'hA5C3_0F96);
    check("f1_sta", {31'd0, ser_sta}, 32'd1);
    check("f1_sdo_loaded", {31'd0, ser_sdo}, 32'd1);

    // Return word 0x80000001 shifted out: 1, thirty zeros, 1, then 0
    din = 32'hF0F0_F0F0;
    send_bits(64'h3C3C_5AA5, 32, cap);
    check("f2_sdo_word", cap, 32'h8000_0001);
    check("f2_sdo_drained", {31'd0, ser_sdo}, 32'd0);
    latch("f2", 1'b1);
    check("f2_dout", dout, 32'h3C3C_5AA5);
    check("f2_sdo_loaded", {31'd0, ser_sdo}, 32'd1);

    // 31 bits: short frame
    send_bits(64'h7FFF_FFFF, 31, cap);
    check("short_sdo_word", cap, 32'h7878_7878);
    latch("short", 1'b0);
    check("short_dout_kept", dout, 32'h3C3C_5AA5);
    check("short_sta", {31'd0, ser_sta}, 32'd0);

    // 33 bits: long frame
    send_bits(64'h1_2222_3333, 33, cap);
    latch("long", 1'b0);
    check("long_dout_kept", dout, 32'h3C3C_5AA5);
    check("long_sta", {31'd0, ser_sta}, 32'd0);

    // Good frame restores status
    din = 32'hAAAA_0000;
    send_bits(64'h0000_FFFF, 32, cap);
    latch("f3", 1'b1);
    check("f3_dout", dout, 32'h0000_FFFF);
    check("f3_sta", {31'd0, ser_sta}, 32'd1);

    // Empty frame: error, tx reloaded from din
    din = 32'hC000_0000;
    latch("empty", 1'b0);
    check("empty_sta", {31'd0, ser_sta}, 32'd0);
    check("empty_dout_kept", dout, 32'h0000_FFFF);
    check("empty_sdo_loaded", {31'd0, ser_sdo}, 32'd1);
    send_bits(64'h1357_9BDF, 32, cap);
    check("f4_sdo_word", cap, 32'hC000_0000);
    latch("f4", 1'b1);
    check("f4_dout", dout, 32'h1357_9BDF);
    check("f4_sta", {31'd0, ser_sta}, 32'd1);

    // Reset after 16 bits, released while ser_clk is high
    send_bits(64'hFFFF, 16, cap);
    @(negedge clk) ser_clk = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 32'h0);
    check("mid_rst_sta", {31'd0, ser_sta}, 32'd0);
    check("mid_rst_sdo", {31'd0, ser_sdo}, 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    v0 = nvalid; e0 = nerr;
    repeat (8) @(negedge clk);
    ser_clk = 1'b0;
    repeat (8) @(negedge clk);
    send_bits(64'h1234_5678, 32, cap);
    latch("after_rst", 1'b1);
    check("after_rst_dout", dout, 32'h1234_5678);
    check("after_rst_nvalid", nvalid - v0, 32'd1);
    check("after_rst_nerr", nerr - e0, 32'd0);

    // ser_clk rise and ser_le rise in the same cycle: bit dropped, 32 counted
    send_bits(64'h0F1E_2D3C, 32, cap);
    @(negedge clk);
    ser_sdi = 1'b1; ser_clk = 1'b1; ser_le = 1'b1;
    pulse_check("same_cyc", 1'b1);
    check("same_cyc_dout", dout, 32'h0F1E_2D3C);
    repeat (6) @(negedge clk);
    ser_clk = 1'b0;
    repeat (8) @(negedge clk);

    // ser_le held high: bits still shift, no latch until it re-rises
    v0 = nvalid; e0 = nerr;
    send_bits(64'hDEAD_BEEF, 32, cap);
    check("le_high_no_pulse", (nvalid - v0) + (nerr - e0), 32'd0);
    ser_le = 1'b0;
    repeat (8) @(negedge clk);
    latch("le_rerise", 1'b1);
    check("le_rerise_dout", dout, 32'hDEAD_BEEF);
    check("le_rerise_sta", {31'd0, ser_sta}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/pnl_serial_target.md
PNL_SERIAL_TARGET -- requirements
Module: pnl_serial_target

Interface
REQ-001 Parameter: WIDTH, 32, serial frame length in bits.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth on serial inputs (min 2).
REQ-003 Port: csi_MCLK_clk  input  1  system clock; the only clock.
REQ-004 Port: rsi_MRST_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: ser_sdi  input  1  serial data from host (host sdo).
REQ-006 Port: ser_clk  input  1  serial shift clock from host, asynchronous to csi_MCLK_clk.
REQ-007 Port: ser_le  input  1  latch enable from host; rising edge ends frame.
REQ-008 Port: ser_sdo  output  1  serial data to host (host sdi).
REQ-009 Port: ser_sta  output  1  status to host; 1 = last frame had exactly WIDTH bits.
REQ-010 Port: din  input  WIDTH  parallel word to return on next frame.
REQ-011 Port: dout  output  WIDTH  last valid received word.
REQ-012 Port: dout_valid  output  1  one-cycle pulse, dout updated.
REQ-013 Port: frame_err  output  1  one-cycle pulse, frame length wrong.

Function
REQ-014 ser_clk, ser_le, ser_sdi SHALL each pass SYNC_STAGES flops; edges detected on synchronized values.
REQ-015 Host contract: ser_clk high and low phases each >= SYNC_STAGES+2 MCLK cycles; ser_sdi stable around ser_clk rise.
REQ-016 States: IDLE (bit count 0), SHIFT (>=1 bit received), LATCH (one cycle).
REQ-017 On synced ser_clk rise: rx shift register shifts left, LSB <= synced ser_sdi (MSB first); bit count +1; IDLE -> SHIFT.
REQ-018 Bit count SHALL saturate at WIDTH+1; rx register keeps last WIDTH bits.
REQ-019 On synced ser_clk fall: tx shift register shifts left, LSB <= 0; ser_sdo = tx MSB.
REQ-020 On synced ser_le rise (any state): -> LATCH; a ser_clk edge detected the same cycle is ignored.
REQ-021 In LATCH: if count == WIDTH, dout <= rx register, dout_valid = 1, ser_sta <= 1; else frame_err = 1, dout unchanged, ser_sta <= 0.
REQ-022 In LATCH: tx register <= din; rx register and bit count cleared; next state IDLE.
REQ-023 Latency: dout/dout_valid/frame_err asserted exactly 1 cycle after the synced ser_le edge is detected.
REQ-024 ser_le rise with 0 bits SHALL give frame_err and reload tx from din.
REQ-025 ser_le held high: no further LATCH until it falls and rises again; ser_clk edges while ser_le high are still shifted.
REQ-026 dout_valid and frame_err SHALL never be high simultaneously.

Reset
REQ-027 Asserting rsi_MRST_reset_n low SHALL immediately clear all state regardless of clock.
REQ-028 Reset values: state IDLE, count 0, rx/tx registers 0, dout 0, ser_sdo 0, ser_sta 0, dout_valid 0, frame_err 0, synchronizers 0.
REQ-029 Reset mid-frame SHALL discard partial frame; no pulse emitted after release.
REQ-030 First ser_clk edge after release SHALL be detected only after synchronizers refill (no false edge from reset value).

Structure
REQ-031 State encoding and default WIDTH/SYNC_STAGES constants SHALL live in shared package pnl_serial_pkg.
REQ-032 One sub-module: pnl_sync_edge (SYNC_STAGES synchronizer plus rise/fall pulse), instantiated three times (ser_sdi uses level only).
REQ-033 Implementation SHALL be synchronous to csi_MCLK_clk only; no logic clocked by ser_clk.

Verification
REQ-034 Shift 32 bits of 0xA5C3_0F96 MSB first, pulse ser_le -> dout = 0xA5C30F96, dout_valid one cycle, ser_sta = 1.
REQ-035 din = 0x8000_0001 at latch, then 32 ser_clk cycles -> ser_sdo sequence 1, 0 x30, 1, then 0.
REQ-036 Shift 31 bits then ser_le -> frame_err one cycle, dout keeps previous, ser_sta = 0; 33 bits -> same.
REQ-037 ser_le rise with no ser_clk -> frame_err, tx reloaded; next good frame -> ser_sta back to 1.
REQ-038 Assert reset after 16 bits, release, send full frame 0x1234_5678 -> only dout = 0x12345678 valid pulse, no stray pulse.
REQ-039 ser_clk rise and ser_le rise synchronized into same cycle -> bit ignored, LATCH taken, count check uses prior count.
